// File: rtl/pipeline_track_if.sv
// Stage control, ID decode and hazard-feedback bundle of pipeline_track.
// slave = the tracker, master = the pipeline controller driving it.
interface pipeline_track_if;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic [31:0] id_inst;
  logic [2:0]  id_pc_src;
  logic        id_mem_ren, id_mem_wen, id_wb_data_src, id_wb_wen;
  logic [1:0]  id_wb_addr_src;
  logic        if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic        is_branch_exe, wb_wen_exe;
  logic [4:0]  regw_addr_exe;
  logic        is_branch_mem, wb_wen_mem;
  logic [4:0]  regw_addr_mem;
  logic        mem_ren_mem, mem_wen_mem;
  logic        wb_wen_wb, wb_data_src_wb;
  logic [4:0]  regw_addr_wb;
  logic [31:0] retired_cnt, bubble_cnt;

  modport slave (
    input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
    input  if_en, id_en, exe_en, mem_en, wb_en,
    input  id_inst, id_pc_src, id_mem_ren, id_mem_wen, id_wb_data_src, id_wb_wen, id_wb_addr_src,
    output if_valid, id_valid, exe_valid, mem_valid, wb_valid,
    output is_branch_exe, wb_wen_exe, regw_addr_exe,
    output is_branch_mem, wb_wen_mem, regw_addr_mem,
    output mem_ren_mem, mem_wen_mem,
    output wb_wen_wb, wb_data_src_wb, regw_addr_wb,
    output retired_cnt, bubble_cnt
  );

  modport master (
    output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
    output if_en, id_en, exe_en, mem_en, wb_en,
    output id_inst, id_pc_src, id_mem_ren, id_mem_wen, id_wb_data_src, id_wb_wen, id_wb_addr_src,
    input  if_valid, id_valid, exe_valid, mem_valid, wb_valid,
    input  is_branch_exe, wb_wen_exe, regw_addr_exe,
    input  is_branch_mem, wb_wen_mem, regw_addr_mem,
    input  mem_ren_mem, mem_wen_mem,
    input  wb_wen_wb, wb_data_src_wb, regw_addr_wb,
    input  retired_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipeline_track.sv
// Shadow pipeline tracker: follows the 5-stage valid/control flow and
// exports registered hazard feedback plus retired/bubble counters.
module pipeline_track #(
  parameter logic [1:0] WB_ADDR_RD   = 2'd0,
  parameter logic [1:0] WB_ADDR_RT   = 2'd1,
  parameter logic [1:0] WB_ADDR_LINK = 2'd2,
  parameter logic [2:0] PC_NEXT      = 3'd0
) (
  input logic              clk,
  input logic              rst,
  pipeline_track_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic       is_branch;
    logic       mem_ren;
    logic       mem_wen;
    logic       wb_wen;
    logic       wb_data_src;
    logic [4:0] regw_addr;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       wb_wen;
    logic       wb_data_src;
    logic [4:0] regw_addr;
  } wb_t;

  logic        if_v, id_v;
  ctrl_t       exe_r, mem_r, id_dec;
  wb_t         wb_r;
  logic [4:0]  dst;
  logic        dst_ok;
  logic [31:0] retired_r, bubble_r;

  always_comb begin
    dst    = 5'd0;
    dst_ok = 1'b1;
    case (bus.id_wb_addr_src)
      WB_ADDR_RD:   dst = bus.id_inst[15:11];
      WB_ADDR_RT:   dst = bus.id_inst[20:16];
      WB_ADDR_LINK: dst = 5'd31;
      default:      dst_ok = 1'b0;
    endcase
  end

  // Writes to $0 or via an unknown select never show up as hazards.
  always_comb begin
    id_dec             = '0;
    id_dec.valid       = id_v;
    id_dec.is_branch   = id_v & (bus.id_pc_src != PC_NEXT);
    id_dec.mem_ren     = id_v & bus.id_mem_ren;
    id_dec.mem_wen     = id_v & bus.id_mem_wen;
    id_dec.wb_wen      = id_v & bus.id_wb_wen & dst_ok & (dst != 5'd0);
    id_dec.wb_data_src = bus.id_wb_data_src;
    id_dec.regw_addr   = dst;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.if_rst)      if_v <= 1'b0;
    else if (bus.if_en)         if_v <= 1'b1;

    if (rst || bus.id_rst)      id_v <= 1'b0;
    else if (bus.id_en)         id_v <= if_v;

    if (rst || bus.exe_rst)     exe_r <= '0;
    else if (bus.exe_en)        exe_r <= id_dec;

    if (rst || bus.mem_rst)     mem_r <= '0;
    else if (bus.mem_en)        mem_r <= exe_r;

    if (rst || bus.wb_rst)      wb_r <= '0;
    else if (bus.wb_en)         wb_r <= '{mem_r.valid, mem_r.wb_wen, mem_r.wb_data_src, mem_r.regw_addr};
  end

  // Counters clear only on global rst; stage-local clears leave them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= '0;
      bubble_r  <= '0;
    end else begin
      if (wb_r.valid && bus.wb_en && !bus.wb_rst) retired_r <= retired_r + 32'd1;
      if (bus.exe_rst && id_v)                    bubble_r  <= bubble_r + 32'd1;
    end
  end

  assign bus.if_valid       = if_v;
  assign bus.id_valid       = id_v;
  assign bus.exe_valid      = exe_r.valid;
  assign bus.mem_valid      = mem_r.valid;
  assign bus.wb_valid       = wb_r.valid;
  assign bus.is_branch_exe  = exe_r.is_branch;
  assign bus.wb_wen_exe     = exe_r.wb_wen;
  assign bus.regw_addr_exe  = exe_r.regw_addr;
  assign bus.is_branch_mem  = mem_r.is_branch;
  assign bus.wb_wen_mem     = mem_r.wb_wen;
  assign bus.regw_addr_mem  = mem_r.regw_addr;
  assign bus.mem_ren_mem    = mem_r.mem_ren;
  assign bus.mem_wen_mem    = mem_r.mem_wen;
  assign bus.wb_wen_wb      = wb_r.wb_wen;
  assign bus.wb_data_src_wb = wb_r.wb_data_src;
  assign bus.regw_addr_wb   = wb_r.regw_addr;
  assign bus.retired_cnt    = retired_r;
  assign bus.bubble_cnt     = bubble_r;

endmodule

// File: doc/pipeline_track.md
PIPELINE_TRACK -- requirements
Module: pipeline_track

Interface
REQ-001 SHALL use parameter WB_ADDR_RD, default 2'd0, meaning the wb_addr_src code that selects destination inst[15:11].
REQ-002 SHALL use parameter WB_ADDR_RT, default 2'd1, meaning the wb_addr_src code that selects inst[20:16].
REQ-003 SHALL use parameter WB_ADDR_LINK, default 2'd2, meaning the wb_addr_src code that selects register 31.
REQ-004 SHALL use parameter PC_NEXT, default 3'd0, meaning the pc_src code for a non-branch instruction.
REQ-005 SHALL have the following ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  input  1 each  per-stage register clear
- if_en, id_en, exe_en, mem_en, wb_en  input  1 each  per-stage register load enable
- id_inst  input  32  instruction currently held in ID
- id_pc_src  input  3  decoded PC source of the ID instruction
- id_mem_ren, id_mem_wen, id_wb_data_src, id_wb_wen  input  1 each  decoded controls
- id_wb_addr_src  input  2  decoded destination select
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  output  1 each  stage-holds-instruction flags
- is_branch_exe, wb_wen_exe  output  1 each  EXE hazard feedback
- regw_addr_exe  output  5  EXE destination register
- is_branch_mem, wb_wen_mem  output  1 each  MEM hazard feedback
- regw_addr_mem  output  5  MEM destination register
- mem_ren_mem, mem_wen_mem  output  1 each  memory strobes for the MEM stage
- wb_wen_wb, wb_data_src_wb  output  1 each  WB controls
- regw_addr_wb  output  5  WB destination register
- retired_cnt  output  32  count of retired instructions
- bubble_cnt  output  32  count of inserted bubbles

Function
REQ-006 Each stage register X SHALL obey this priority, evaluated on the rising edge of clk:
- rst or X_rst: clear valid and all fields to 0.
- else X_en: load from the upstream stage.
- else: hold.
REQ-007 The IF stage SHALL load if_valid with 1.
REQ-008 The ID stage SHALL load id_valid with if_valid.
REQ-009 The EXE stage SHALL load the following from ID:
- valid = id_valid;
- is_branch = id_valid & (id_pc_src != PC_NEXT);
- mem_ren, mem_wen, wb_wen, each ANDed with id_valid;
- wb_data_src;
- regw_addr, computed per REQ-010.
REQ-010 regw_addr SHALL be computed as follows:
- id_wb_addr_src=WB_ADDR_RD gives id_inst[15:11];
- WB_ADDR_RT gives id_inst[20:16];
- WB_ADDR_LINK gives 5'd31;
- any other code gives 5'd0, and wb_wen is forced to 0.
REQ-011 If the computed regw_addr is 0, the loaded wb_wen SHALL be 0 (writes to $0 are never reported).
REQ-012 The MEM stage SHALL load all EXE fields unchanged.
REQ-013 The WB stage SHALL load valid, wb_wen, wb_data_src and regw_addr from MEM.
REQ-014 All feedback outputs SHALL be driven directly from stage registers (zero combinational paths from inputs), valid one cycle after the load edge.
REQ-015 retired_cnt SHALL increment by 1 on each clock where wb_valid=1, wb_en=1, wb_rst=0 and rst=0, wrapping from 0xFFFFFFFF to 0.
REQ-016 bubble_cnt SHALL increment by 1 on each clock where exe_rst=1, id_valid=1 and rst=0, wrapping likewise.
REQ-017 X_rst and X_en asserted together SHALL clear the stage, not load it.
REQ-018 All stages disabled (debug freeze) SHALL hold every register, and retired_cnt SHALL not change.
REQ-019 A stall pattern (if_en=id_en=0, exe_rst=1) SHALL hold IF/ID, insert an invalid EXE entry, and let MEM/WB advance.

Reset
REQ-020 While rst=1, all valid flags, stage fields, feedback outputs and both counters SHALL be 0 at the next edge, overriding every X_en.
REQ-021 Stage-local X_rst SHALL NOT clear the counters.

Verification
REQ-022 The bench SHALL cover: rst for 3 cycles, then all en=1 and all X_rst=0 -> if_valid=1 after edge 1, id_valid after edge 2, exe_valid after edge 3, mem_valid after edge 4, wb_valid after edge 5, counters 0.
REQ-023 The bench SHALL cover: ID holds ADD with rd=5, wb_addr_src=0, wb_wen=1 -> regw_addr_exe=5 and wb_wen_exe=1 after the next edge; regw_addr_mem=5 and wb_wen_mem=1 one edge later; retired_cnt +1 when the instruction leaves WB.
REQ-024 The bench SHALL cover: JAL with pc_src=3'd1 and wb_addr_src=2 -> is_branch_exe=1 and regw_addr_exe=31; ADDI with rt=0 -> wb_wen_exe=0.
REQ-025 The bench SHALL cover: stall for 2 cycles (if_en=id_en=0, exe_rst=1) -> id_valid held, exe_valid=0, wb_wen_exe=0, bubble_cnt +2.
REQ-026 The bench SHALL cover: exe_rst=exe_en=1 with a valid ID instruction -> exe_valid=0; then all en=0 for 4 cycles -> all outputs unchanged and retired_cnt constant.
REQ-027 The bench SHALL cover: rst asserted mid-stream with 5 valid stages -> all flags and counters 0 after one edge.
